// File: rtl/pll_reconfig_pkg.sv
// Shared constants for the PLL reconfiguration controller: management-port
// register map, counter-field encoder, preset table and FSM state codes.
package pll_reconfig_pkg;

  localparam int NUM_PRESETS = 2;
  localparam int SEL_W = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1;

  // Reconfiguration IP register addresses
  localparam logic [5:0] ADDR_MODE  = 6'd0;
  localparam logic [5:0] ADDR_START = 6'd2;
  localparam logic [5:0] ADDR_N     = 6'd3;
  localparam logic [5:0] ADDR_M     = 6'd4;
  localparam logic [5:0] ADDR_C0    = 6'd5;

  // Fixed data words
  localparam logic [31:0] MODE_WAITREQ = 32'd0;  // waitrequest mode
  localparam logic [31:0] START_GO     = 32'd1;
  localparam logic [7:0]  N_DIV        = 8'd1;   // N counter bypassed

  // FSM state codes
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_WR_MODE   = 4'd1;
  localparam logic [3:0] ST_WR_N      = 4'd2;
  localparam logic [3:0] ST_WR_M      = 4'd3;
  localparam logic [3:0] ST_WR_C0     = 4'd4;
  localparam logic [3:0] ST_WR_START  = 4'd5;
  localparam logic [3:0] ST_BLANK     = 4'd6;
  localparam logic [3:0] ST_WAIT_LOCK = 4'd7;
  localparam logic [3:0] ST_FINISH    = 4'd8;

  // One preset: total division ratios of the M feedback and C0 output counters
  typedef struct packed {
    logic [7:0] m_div;
    logic [7:0] c0_div;
  } preset_t;

  // Preset 0 is the power-on 56 MHz setting (50*28/25), preset 1 is 32 MHz (50*32/50).
  function automatic preset_t preset_lookup(input logic [SEL_W-1:0] sel);
    preset_t p;
    case (sel)
      SEL_W'(1): p = '{m_div: 8'd32, c0_div: 8'd50};
      default:   p = '{m_div: 8'd28, c0_div: 8'd25};
    endcase
    return p;
  endfunction

  // Encode a division ratio into the IP counter word:
  // bit17 odd, bit16 bypass, [15:8] high count, [7:0] low count.
  // An odd ratio puts the extra cycle into the high phase.
  function automatic logic [31:0] counter_word(input logic [7:0] div);
    logic [31:0] word;
    logic [7:0]  lo;
    logic [7:0]  hi;
    word = 32'd0;
    lo   = div >> 1;
    hi   = div - lo;
    if (div <= 8'd1) begin
      word[16] = 1'b1;
    end else begin
      word[17]   = div[0];
      word[15:8] = hi;
      word[7:0]  = lo;
    end
    return word;
  endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// Avalon-MM management port of the PLL reconfiguration IP.
interface pll_reconfig_ctrl_if;
  logic [5:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic        read;

  modport master (
    output address,
    output write,
    output writedata,
    output read,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  write,
    input  writedata,
    input  read,
    output waitrequest
  );
endinterface

// File: rtl/pll_reconfig_ctrl_lock_monitor.sv
// Synchronizes the asynchronous PLL lock flag and measures how long it has
// been continuously high. lock_stable is high once the run length saturates.
module pll_reconfig_ctrl_lock_monitor #(
  parameter int LOCK_STABLE = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic locked_async,
  input  logic clear,
  output logic lock_stable
);

  localparam int CNT_W = $clog2(LOCK_STABLE + 1);
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(LOCK_STABLE);

  logic             sync1_reg;
  logic             sync2_reg;
  logic [CNT_W-1:0] count_reg;

  // Two-flop synchronizer for the lock flag
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= locked_async;
      sync2_reg <= sync1_reg;
    end
  end

  // Run-length of synchronized lock; any low sample or clear restarts it
  always_ff @(posedge clk) begin
    if (rst || clear || !sync2_reg) begin
      count_reg <= '0;
    end else if (count_reg != STABLE_MAX) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign lock_stable = (count_reg == STABLE_MAX);

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL output-frequency change sequencer: writes a preset into the PLL
// reconfiguration IP, waits for re-lock and drives a lock-qualified reset.
module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int LOCK_BLANK   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 5000000
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_sel,
  output logic             req_ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [SEL_W-1:0] cur_sel,
  output logic             sys_reset,
  input  logic             pll_locked,
  pll_reconfig_ctrl_if.master mgmt
);

  localparam int BLANK_W = $clog2(LOCK_BLANK + 1);
  localparam int TO_W    = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(LOCK_BLANK - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(LOCK_TIMEOUT - 1);

  logic [3:0]         state_reg;
  logic [3:0]         state_next;
  logic [SEL_W-1:0]   sel_reg;
  logic [SEL_W-1:0]   cur_sel_reg;
  logic               error_reg;
  logic               ready_reg;
  logic               sys_reset_reg;
  logic [BLANK_W-1:0] blank_cnt_reg;
  logic [TO_W-1:0]    timeout_cnt_reg;

  logic    accept;
  logic    write_done;
  logic    lock_clear;
  logic    lock_stable;
  logic    timeout_hit;
  preset_t preset;

  assign accept      = req_valid && ready_reg;
  assign write_done  = mgmt.write && !mgmt.waitrequest;
  assign timeout_hit = (timeout_cnt_reg == TO_LAST);
  assign preset      = preset_lookup(sel_reg);

  // Hold the stability count at zero until blanking has finished
  assign lock_clear = (state_reg == ST_WR_MODE) || (state_reg == ST_WR_N) ||
                      (state_reg == ST_WR_M)    || (state_reg == ST_WR_C0) ||
                      (state_reg == ST_WR_START) || (state_reg == ST_BLANK);

  pll_reconfig_ctrl_lock_monitor #(
    .LOCK_STABLE(LOCK_STABLE)
  ) u_lock_monitor (
    .clk         (refclk),
    .rst         (rst),
    .locked_async(pll_locked),
    .clear       (lock_clear),
    .lock_stable (lock_stable)
  );

  // Next-state logic; each write advances only when the IP accepts it
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (accept) state_next = ST_WR_MODE;
      ST_WR_MODE:   if (write_done) state_next = ST_WR_N;
      ST_WR_N:      if (write_done) state_next = ST_WR_M;
      ST_WR_M:      if (write_done) state_next = ST_WR_C0;
      ST_WR_C0:     if (write_done) state_next = ST_WR_START;
      ST_WR_START:  if (write_done) state_next = ST_BLANK;
      ST_BLANK:     if (blank_cnt_reg == BLANK_LAST) state_next = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (lock_stable || timeout_hit) state_next = ST_FINISH;
      ST_FINISH:    state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // State register and request handshake
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next == ST_IDLE);
    end
  end

  // Latch the requested preset and track the applied preset / error flag
  always_ff @(posedge refclk) begin
    if (rst) begin
      sel_reg     <= '0;
      cur_sel_reg <= '0;
      error_reg   <= 1'b0;
    end else if (accept) begin
      sel_reg   <= req_sel;
      error_reg <= 1'b0;
    end else if (state_reg == ST_WAIT_LOCK) begin
      if (lock_stable) begin
        cur_sel_reg <= sel_reg;
      end else if (timeout_hit) begin
        error_reg <= 1'b1;
      end
    end
  end

  // Blanking counter: runs only in BLANK and parks on its last value
  always_ff @(posedge refclk) begin
    if (rst || (state_reg != ST_BLANK)) begin
      blank_cnt_reg <= '0;
    end else if (blank_cnt_reg != BLANK_LAST) begin
      blank_cnt_reg <= blank_cnt_reg + BLANK_W'(1);
    end
  end

  // Lock timeout counter: runs only in WAIT_LOCK and saturates
  always_ff @(posedge refclk) begin
    if (rst || (state_reg != ST_WAIT_LOCK)) begin
      timeout_cnt_reg <= '0;
    end else if (!timeout_hit) begin
      timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
    end
  end

  // Downstream reset: asserted with busy, released one cycle after lock saturates
  always_ff @(posedge refclk) begin
    if (rst) begin
      sys_reset_reg <= 1'b1;
    end else begin
      sys_reset_reg <= (state_next != ST_IDLE) || !lock_stable;
    end
  end

  // Management-port write decode; address/data depend only on state and latched preset
  always_comb begin
    mgmt.write     = 1'b0;
    mgmt.address   = '0;
    mgmt.writedata = '0;
    case (state_reg)
      ST_WR_MODE: begin
        mgmt.write     = 1'b1;
        mgmt.address   = ADDR_MODE;
        mgmt.writedata = MODE_WAITREQ;
      end
      ST_WR_N: begin
        mgmt.write     = 1'b1;
        mgmt.address   = ADDR_N;
        mgmt.writedata = counter_word(N_DIV);
      end
      ST_WR_M: begin
        mgmt.write     = 1'b1;
        mgmt.address   = ADDR_M;
        mgmt.writedata = counter_word(preset.m_div);
      end
      ST_WR_C0: begin
        mgmt.write     = 1'b1;
        mgmt.address   = ADDR_C0;
        mgmt.writedata = counter_word(preset.c0_div);
      end
      ST_WR_START: begin
        mgmt.write     = 1'b1;
        mgmt.address   = ADDR_START;
        mgmt.writedata = START_GO;
      end
      default: begin
      end
    endcase
  end

  assign mgmt.read = 1'b0;
  assign req_ready = ready_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_FINISH);
  assign error     = error_reg;
  assign cur_sel   = cur_sel_reg;
  assign sys_reset = sys_reset_reg;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Bench for pll_reconfig_ctrl: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a phase-level reference model.
module tb_pll_reconfig_ctrl;
  import pll_reconfig_pkg::*;

  localparam int LB = 16;
  localparam int LS = 20;
  localparam int LT = 300;

  logic             refclk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic [SEL_W-1:0] req_sel;
  logic             req_ready;
  logic             busy;
  logic             done;
  logic             error;
  logic [SEL_W-1:0] cur_sel;
  logic             sys_reset;
  logic             pll_locked;

  pll_reconfig_ctrl_if mgmt_bus();

  pll_reconfig_ctrl #(
    .LOCK_BLANK  (LB),
    .LOCK_STABLE (LS),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cur_sel   (cur_sel),
    .sys_reset (sys_reset),
    .pll_locked(pll_locked),
    .mgmt      (mgmt_bus)
  );

  always #5 refclk = ~refclk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_edge = -1;
  int done_edge = -1;
  int txn = 0;
  logic [37:0] wlog[$];

  logic [5:0]  lit_addr [5] = '{6'd0, 6'd3, 6'd4, 6'd5, 6'd2};
  logic [31:0] lit_data1[5] = '{32'h0, 32'h00010000, 32'h00001010, 32'h00001919, 32'h1};

  // ---------------- reference model (sequence phases, not RTL states) -------
  typedef enum int {P_IDLE, P_WRITE, P_BLANK, P_WAIT, P_FINISH} phase_e;
  phase_e m_phase = P_IDLE;
  int m_widx, m_bcnt, m_wcnt, m_stab, m_sel, m_cur;
  bit m_err, m_ready, m_sysrst = 1'b1, m_s1, m_s2;

  function automatic logic [37:0] exp_write(input int idx, input int sel);
    case (idx)
      0:       return {6'd0, 32'h00000000};
      1:       return {6'd3, 32'h00010000};
      2:       return {6'd4, (sel != 0) ? 32'h00001010 : 32'h00000E0E};
      3:       return {6'd5, (sel != 0) ? 32'h00001919 : 32'h00020D0C};
      default: return {6'd2, 32'h00000001};
    endcase
  endfunction

  task automatic model_edge();
    bit full_before;
    full_before = (m_stab == LS);
    if (rst) begin
      m_phase = P_IDLE; m_err = 0; m_cur = 0; m_sel = 0;
      m_s1 = 0; m_s2 = 0; m_stab = 0; m_ready = 0; m_sysrst = 1;
      return;
    end
    if (m_phase == P_WRITE || m_phase == P_BLANK || !m_s2) m_stab = 0;
    else if (m_stab < LS) m_stab++;
    m_s2 = m_s1;
    m_s1 = pll_locked;
    case (m_phase)
      P_IDLE: if (req_valid && m_ready) begin
        m_sel = int'(req_sel); m_err = 0; m_phase = P_WRITE; m_widx = 0;
      end
      P_WRITE: if (!mgmt_bus.waitrequest) begin
        if (m_widx == 4) begin m_phase = P_BLANK; m_bcnt = 0; end
        else m_widx++;
      end
      P_BLANK: begin
        m_bcnt++;
        if (m_bcnt == LB) begin m_phase = P_WAIT; m_wcnt = 0; end
      end
      P_WAIT: begin
        if (full_before) begin m_phase = P_FINISH; m_cur = m_sel; end
        else begin
          m_wcnt++;
          if (m_wcnt == LT) begin m_phase = P_FINISH; m_err = 1; end
        end
      end
      default: m_phase = P_IDLE;
    endcase
    m_ready  = (m_phase == P_IDLE);
    m_sysrst = (m_phase != P_IDLE) || !full_before;
  endtask

  // ---------------- comparison helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic [37:0] ew;
    ew = (m_phase == P_WRITE) ? exp_write(m_widx, m_sel) : 38'd0;
    chk("req_ready", 32'(req_ready), 32'(m_ready));
    chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
    chk("done", 32'(done), 32'(m_phase == P_FINISH));
    chk("error", 32'(error), 32'(m_err));
    chk("cur_sel", 32'(cur_sel), 32'(m_cur));
    chk("sys_reset", 32'(sys_reset), 32'(m_sysrst));
    chk("mgmt_write", 32'(mgmt_bus.write), 32'(m_phase == P_WRITE));
    chk("mgmt_address", 32'(mgmt_bus.address), 32'(ew[37:32]));
    chk("mgmt_writedata", mgmt_bus.writedata, ew[31:0]);
    chk("mgmt_read", 32'(mgmt_bus.read), 32'd0);
  endtask

  // One clock: log the write completing at this edge, advance model, compare
  task automatic step();
    if (!rst && mgmt_bus.write === 1'b1 && mgmt_bus.waitrequest === 1'b0) begin
      wlog.push_back({mgmt_bus.address, mgmt_bus.writedata});
      if (mgmt_bus.address === 6'd2) start_edge = cyc + 1;
    end
    @(posedge refclk);
    cyc++;
    model_edge();
    #2;
    check_outputs();
    if (done === 1'b1) begin
      done_edge = cyc;
      txn++;
      $display("txn %0d: done at cycle %0d error=%0b cur_sel=%0d", txn, cyc, error, cur_sel);
    end
  endtask

  task automatic wait_done(input int bound, output bit seen);
    seen = 0;
    for (int k = 0; k < bound && !seen; k++) begin
      step();
      if (done === 1'b1) seen = 1;
    end
  endtask

  task automatic wait_addr(input logic [5:0] a, input int bound, output bit seen);
    seen = 0;
    for (int k = 0; k < bound && !seen; k++) begin
      step();
      if (mgmt_bus.write === 1'b1 && mgmt_bus.address === a) seen = 1;
    end
  endtask

  task automatic request(input int sel);
    req_sel = SEL_W'(sel);
    req_valid = 1;
    step();
    req_valid = 0;
  endtask

  initial begin
    bit seen;
    int n;
    int held;
    int low_left;

    rst = 1; req_valid = 0; req_sel = '0; pll_locked = 1;
    mgmt_bus.waitrequest = 0;

    // Reset with lock already present
    repeat (3) step();
    chk("rst_sys_reset", 32'(sys_reset), 32'd1);
    chk("rst_write", 32'(mgmt_bus.write), 32'd0);
    rst = 0;
    n = 0;
    for (int k = 0; k < LS + 50; k++) begin
      step();
      if (k == 0) chk("ready_after_rst", 32'(req_ready), 32'd1);
      if (sys_reset === 1'b1) n++;
      else break;
    end
    chk("release_len", n, 2 + LS);

    // Preset 1, no stalls, lock dropped for 50 cycles after START
    wlog.delete();
    start_edge = -1;
    request(1);
    for (int k = 0; k < 50 && start_edge < 0; k++) step();
    pll_locked = 0;
    repeat (50) step();
    pll_locked = 1;
    wait_done(2000, seen);
    chk("seq1_done", 32'(seen), 32'd1);
    chk("seq1_wr_count", wlog.size(), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      chk($sformatf("seq1_wr%0d_addr", i), 32'(wlog[i][37:32]), 32'(lit_addr[i]));
      chk($sformatf("seq1_wr%0d_data", i), wlog[i][31:0], lit_data1[i]);
    end
    chk("seq1_cur_sel", 32'(cur_sel), 32'd1);
    repeat (LS + 10) step();

    // Reset during the C0 write
    chk("pre_abort_cur_sel", 32'(cur_sel), 32'd1);
    request(0);
    wait_addr(6'd5, 20, seen);
    chk("abort_reached_c0", 32'(seen), 32'd1);
    rst = 1;
    step();
    chk("abort_write", 32'(mgmt_bus.write), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cur_sel", 32'(cur_sel), 32'd0);
    rst = 0;
    repeat (LS + 10) step();

    // Stall on the M write; requests while busy must be ignored
    wlog.delete();
    request(0);
    wait_addr(6'd4, 20, seen);
    chk("stall_reached_m", 32'(seen), 32'd1);
    mgmt_bus.waitrequest = 1;
    held = 0;
    for (int k = 0; k < 5; k++) begin
      req_valid = (k == 1 || k == 3);
      req_sel = SEL_W'(1);
      step();
      if (mgmt_bus.write === 1'b1 && mgmt_bus.address === 6'd4 &&
          mgmt_bus.writedata === 32'h00000E0E) held++;
    end
    req_valid = 0;
    mgmt_bus.waitrequest = 0;
    step();
    chk("stall_hold", held, 5);
    chk("after_stall_addr", 32'(mgmt_bus.address), 32'd5);
    wait_done(2000, seen);
    chk("seq2_done", 32'(seen), 32'd1);
    chk("seq2_wr_count", wlog.size(), 5);
    chk("seq2_cur_sel", 32'(cur_sel), 32'd0);
    repeat (LS + 10) step();

    // Lock never returns: timeout
    start_edge = -1;
    request(1);
    for (int k = 0; k < 50 && start_edge < 0; k++) step();
    pll_locked = 0;
    wait_done(LB + LT + 50, seen);
    chk("timeout_done", 32'(seen), 32'd1);
    chk("timeout_latency", done_edge - start_edge, LB + LT);
    chk("timeout_error", 32'(error), 32'd1);
    chk("timeout_cur_sel", 32'(cur_sel), 32'd0);
    chk("timeout_sys_reset", 32'(sys_reset), 32'd1);
    repeat (10) step();
    pll_locked = 1;
    repeat (LS + 10) step();

    // Randomized traffic
    low_left = 0;
    for (int i = 0; i < 6000; i++) begin
      req_valid = ($urandom_range(0, 7) == 0);
      req_sel = SEL_W'($urandom_range(0, NUM_PRESETS - 1));
      mgmt_bus.waitrequest = ($urandom_range(0, 3) == 0);
      if (low_left > 0) begin
        pll_locked = 0;
        low_left--;
      end else begin
        pll_locked = 1;
        if ($urandom_range(0, 199) == 0) low_left = $urandom_range(1, 400);
      end
      rst = ($urandom_range(0, 1999) == 0);
      step();
    end
    rst = 0;
    req_valid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
